// File: rtl/repsub_divider_if.sv
// rtl/repsub_divider_if.sv - start/done handshake bundle for the repeated-subtraction divider
interface repsub_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/repsub_divider.sv
// rtl/repsub_divider.sv - sequential unsigned divider, one subtraction of the divisor per cycle
module repsub_divider #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  repsub_divider_if.slave io_div
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SUB   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_b_zero;
  logic             w_can_sub;

  assign w_b_zero  = (r_b == '0);
  assign w_can_sub = (r_a >= r_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (io_div.start) w_next_state = S_CHECK;
      S_CHECK: w_next_state = w_b_zero ? S_DONE : S_SUB;
      S_SUB:   if (!w_can_sub) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // busy/done are registered copies of the state being entered, so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a           <= '0;
      r_b           <= '0;
      r_q           <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (io_div.start) begin
            r_a <= io_div.dividend;
            r_b <= io_div.divisor;
            r_q <= '0;
          end
        end
        S_CHECK: begin
          if (w_b_zero) begin
            r_quotient    <= '1;
            r_remainder   <= r_a;
            r_div_by_zero <= 1'b1;
          end
        end
        S_SUB: begin
          if (w_can_sub) begin
            r_a <= r_a - r_b;
            r_q <= r_q + 1'b1;
          end else begin
            r_quotient    <= r_q;
            r_remainder   <= r_a;
            r_div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_div.quotient    = r_quotient;
  assign io_div.remainder   = r_remainder;
  assign io_div.div_by_zero = r_div_by_zero;
  assign io_div.busy        = r_busy;
  assign io_div.done        = r_done;

endmodule

// File: tb/tb_repsub_divider.sv
// tb/tb_repsub_divider.sv - self-checking bench for repsub_divider
module tb_repsub_divider;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  repsub_divider_if #(.WIDTH(W)) dif ();

  repsub_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_div (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    bit           noise;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, all-ones quotient on a zero divisor
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output int lat);
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 2;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = int'(a / b) + 3;
    end
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat, input bit noise,
                        input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk);
    lat = 1;
    #1;
    if (!noise) dif.start = 1'b0;
    chk({tag, " busy_after_start"}, int'(dif.busy), 1);
    seen = 1'b0;
    while (!seen && lat < 70000) begin
      if (dif.done) begin
        seen = 1'b1;
      end else begin
        if (noise) begin
          dif.dividend = (lat % 2 == 0) ? W'(7) : W'($urandom);
          dif.divisor  = (lat % 2 == 0) ? W'(7) : W'($urandom);
        end
        @(posedge clk);
        lat++;
        #1;
      end
    end
    chk({tag, " done_seen"}, int'(seen), 1);
    if (!seen) return;
    chk({tag, " latency"}, lat, elat);
    chk({tag, " quotient"}, int'(dif.quotient), int'(eq));
    chk({tag, " remainder"}, int'(dif.remainder), int'(er));
    chk({tag, " div_by_zero"}, int'(dif.div_by_zero), int'(edz));
    chk({tag, " busy_in_done"}, int'(dif.busy), 1);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    chk({tag, " done_one_cycle"}, int'(dif.done), 0);
    chk({tag, " busy_cleared"}, int'(dif.busy), 0);
    if (noise) begin
      repeat (2) @(posedge clk);
      #1;
      chk({tag, " start_in_done_ignored"}, int'(dif.busy), 0);
      chk({tag, " quotient_hold"}, int'(dif.quotient), int'(eq));
      chk({tag, " remainder_hold"}, int'(dif.remainder), int'(er));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         mdz;
    int           mlat;
    int           lim;

    n_tests = 0;
    n_fail  = 0;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;

    vt[0] = '{16'd100,   16'd7, 16'd14,     16'd2,  1'b0, 17,    1'b0};
    vt[1] = '{16'd5,     16'd9, 16'd0,      16'd5,  1'b0, 3,     1'b0};
    vt[2] = '{16'hFFFF,  16'd1, 16'hFFFF,   16'd0,  1'b0, 65538, 1'b0};
    vt[3] = '{16'd42,    16'd0, 16'hFFFF,   16'd42, 1'b1, 2,     1'b0};
    vt[4] = '{16'd10,    16'd3, 16'd3,      16'd1,  1'b0, 6,     1'b0};
    vt[5] = '{16'd50,    16'd5, 16'd10,     16'd0,  1'b0, 13,    1'b1};
    vt[6] = '{16'd0,     16'd5, 16'd0,      16'd0,  1'b0, 3,     1'b0};
    vt[7] = '{16'd7,     16'd7, 16'd1,      16'd0,  1'b0, 4,     1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset quotient", int'(dif.quotient), 0);
    chk("reset remainder", int'(dif.remainder), 0);
    chk("reset dz", int'(dif.div_by_zero), 0);
    chk("reset busy", int'(dif.busy), 0);
    chk("reset done", int'(dif.done), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_div(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].lat,
             vt[i].noise, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a long division must wipe all visible state
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 16'd1000;
    dif.divisor  = 16'd1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midreset quotient", int'(dif.quotient), 0);
    chk("midreset remainder", int'(dif.remainder), 0);
    chk("midreset busy", int'(dif.busy), 0);
    chk("midreset done", int'(dif.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("postreset idle", int'(dif.busy), 0);
    do_div(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 6, 1'b0, "after_reset");

    for (int i = 0; i < 25; i++) begin
      rb = W'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) rb = '0;
      lim = (int'(rb) * 64 > 65535) ? 65535 : int'(rb) * 64;
      ra = (rb == 0) ? W'($urandom) : W'($urandom_range(0, lim));
      model(ra, rb, mq, mr, mdz, mlat);
      do_div(ra, rb, mq, mr, mdz, mlat, 1'b0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/repsub_divider.md
# repsub_divider

Sequential unsigned integer divider built on repeated subtraction; it is the inverse companion to the team's repeated-addition multiplier. It combines the control FSM and the datapath in one block. It accepts a dividend/divisor pair on a start pulse and subtracts the divisor once per cycle until the remainder is below the divisor. It then reports quotient, remainder and a one-cycle done strobe. It sits beside the multiplier in the arithmetic unit and uses the same start/done handshake style.

## Interface

- WIDTH, 16, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- quotient  output  WIDTH  registered result; holds until next result
- remainder  output  WIDTH  registered result; holds until next result
- done  output  1  one-cycle strobe: results valid and just updated
- busy  output  1  high from accepted start until the DONE cycle, inclusive
- div_by_zero  output  1  registered flag; updated with results

## Operation

- Internal registers:
  - a_r (WIDTH): running remainder
  - b_r (WIDTH): divisor
  - q_r (WIDTH): running quotient
- States: IDLE, CHECK, SUB, DONE. Use a dedicated state register. All outputs are registered.
- IDLE: busy=0, done=0.
  - start=1 → capture a_r=dividend, b_r=divisor, q_r=0; go to CHECK.
  - start=0 → stay in IDLE.
- CHECK: busy=1.
  - b_r==0 → go to DONE; load quotient={WIDTH{1}}, remainder=a_r, div_by_zero=1.
  - Otherwise go to SUB.
- SUB: busy=1.
  - a_r>=b_r (unsigned) → a_r<=a_r-b_r, q_r<=q_r+1; stay in SUB.
  - Otherwise go to DONE; load quotient=q_r, remainder=a_r, div_by_zero=0.
- DONE: done=1, busy=1 for exactly one cycle; then unconditionally go to IDLE.
- Arithmetic rules:
  - Subtraction is never taken when a_r<b_r, so it cannot underflow.
  - q_r cannot exceed the dividend, so it never wraps.
  - The worst case is divisor=1 with dividend=2^WIDTH−1.
- start is ignored in CHECK, SUB and DONE; there is no queuing.
- The dividend and divisor inputs may change freely after capture without affecting the operation.
- quotient, remainder and div_by_zero change only on the edge entering DONE. At all other times they hold the last result.

## Timing

- Reset (async assert, any time): state=IDLE; all outputs and internal registers are 0. Reset mid-operation abandons the division and leaves no partial results visible.
- Deassert reset synchronously with respect to clk, per the system reset scheme.
- Let edge E0 be the edge that samples start=1 in IDLE.
- Normal division, quotient value q:
  - CHECK after E0, SUB after E1.
  - Subtractions on edges E2..E(q+1); the failing compare on E(q+2) enters DONE.
  - done is high during the cycle after E(q+2), i.e. q+3 edges after E0.
- Divide by zero: DONE is entered on E1; done is high 2 edges after E0.
- Earliest back-to-back operation: start may be asserted in the DONE cycle but is ignored. The next start is accepted on the first IDLE cycle, i.e. one cycle after done.
- busy rises on E0, falls on the edge leaving DONE.
- Latency bound: WIDTH=16 → at most 65538 edges.

## Test plan

- Reset sequence: hold rst high, then pulse rst mid-SUB → all outputs 0 and state IDLE. After release, a new 9/3 → quotient=3, remainder=0.
- 100/7 (WIDTH=16) → done exactly 17 edges after start edge; quotient=14, remainder=2, div_by_zero=0, done high one cycle.
- 5/9 → zero subtractions; done 3 edges after start; quotient=0, remainder=5.
- 0xFFFF/1 → quotient=0xFFFF, remainder=0; done 65538 edges after start; no wrap.
- 42/0 → done 2 edges after start; quotient=0xFFFF, remainder=42, div_by_zero=1. A following 10/3 clears the flag: quotient=3, remainder=1, div_by_zero=0.
- Start 50/5, then assert start with 7/7 while busy and during the DONE cycle, changing dividend/divisor mid-run → both ignored; result is quotient=10, remainder=0. Outputs hold between operations.
